pipe_skid_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_skid_reg.sv | 80 ++++++++
 tb/tb_pipe_skid_reg.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline registers between processor stages.
package pipe_pkg;

    localparam int unsigned PIPE_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        PS_EMPTY,
        PS_BUSY,
        PS_FULL
    } pipe_state_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// Elastic stage register with a one-entry skid buffer, so in_ready is a pure flop output.
// Strict FIFO order; flush drops all held entries, rst also clears the data registers.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = PIPE_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] pipelined_out
);

    pipe_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_xfer;
    logic             out_xfer;

    assign in_ready      = (state_q != PS_FULL);
    assign out_valid     = (state_q != PS_EMPTY);
    assign pipelined_out = main_q;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Data registers keep their contents; only the occupancy is dropped.
            state_d = PS_EMPTY;
        end else begin
            unique case (state_q)
                PS_EMPTY: begin
                    if (in_xfer) begin
                        main_d  = in;
                        state_d = PS_BUSY;
                    end
                end
                PS_BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in;
                    end else if (in_xfer) begin
                        skid_d  = in;
                        state_d = PS_FULL;
                    end else if (out_xfer) begin
                        state_d = PS_EMPTY;
                    end
                end
                PS_FULL: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = PS_BUSY;
                    end
                end
                default: state_d = PS_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PS_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: reset, streaming, stall, flush, reset mid-stall,
// then a randomized handshake run checked against a queue model.
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pipelined_out;

    int errors = 0;
    int checks = 0;

    pipe_skid_reg #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in           (in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .pipelined_out(pipelined_out)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled and inputs changed 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_empty(input string tag);
        check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".in_ready"},  {31'd0, in_ready},  32'd1);
    endtask

    task automatic check_out(input string tag, input logic [31:0] exp, input logic exp_rdy);
        check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".data"},      pipelined_out,      exp);
        check({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, exp_rdy});
    endtask

    initial begin
        logic [31:0] model_q[$];
        logic        exp_in_ready;

        // Reset with a live offer on the input: nothing may be captured.
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in = 32'hDEADBEEF; out_ready = 1'b0;
        step();
        step();
        check_empty("reset");
        check("reset.data", pipelined_out, 32'h0);
        rst = 1'b0; in_valid = 1'b0;
        step();
        check_empty("post_reset");
        check("post_reset.data", pipelined_out, 32'h0);

        // Streaming: eight words back-to-back, one-cycle latency.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in = 32'(i);
            step();
            check_out($sformatf("stream%0d", i), 32'(i), 1'b1);
        end
        in_valid = 1'b0;
        step();
        check_empty("stream_drain");

        // Stall: second word lands in skid, third waits on in_ready.
        in_valid = 1'b1; in = 32'hA5A5A5A5; out_ready = 1'b1;
        step();
        check_out("stall.first", 32'hA5A5A5A5, 1'b1);
        in = 32'h5A5A5A5A; out_ready = 1'b0;
        step();
        check_out("stall.full", 32'hA5A5A5A5, 1'b0);
        in = 32'h12345678;
        step();
        check_out("stall.hold1", 32'hA5A5A5A5, 1'b0);
        step();
        check_out("stall.hold2", 32'hA5A5A5A5, 1'b0);
        out_ready = 1'b1;
        step();
        check_out("stall.drain_skid", 32'h5A5A5A5A, 1'b1);
        step();
        check_out("stall.drain_third", 32'h12345678, 1'b1);
        in_valid = 1'b0;
        step();
        check_empty("stall.empty");

        // Flush while FULL with an input offered in the same cycle.
        out_ready = 1'b0; in_valid = 1'b1; in = 32'h11111111;
        step();
        in = 32'h22222222;
        step();
        check_out("flush.pre", 32'h11111111, 1'b0);
        flush = 1'b1; in = 32'hFFFFFFFF;
        step();
        check_empty("flush.after");
        check("flush.data_kept", pipelined_out, 32'h11111111);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        check_empty("flush.no_ghost");
        in_valid = 1'b1; in = 32'h33333333;
        step();
        check_out("flush.next_push", 32'h33333333, 1'b1);
        in_valid = 1'b0;
        step();
        check_empty("flush.empty");

        // Reset together with flush while FULL.
        out_ready = 1'b0; in_valid = 1'b1; in = 32'h44444444;
        step();
        in = 32'h55555555;
        step();
        check_out("rst_stall.pre", 32'h44444444, 1'b0);
        rst = 1'b1; flush = 1'b1; in = 32'h66666666;
        step();
        check_empty("rst_stall.after");
        check("rst_stall.data", pipelined_out, 32'h0);
        rst = 1'b0; flush = 1'b0; in = 32'hCAFEF00D; out_ready = 1'b1;
        step();
        check_out("rst_stall.push", 32'hCAFEF00D, 1'b1);
        in_valid = 1'b0;
        step();
        check_empty("rst_stall.empty");

        // Random handshakes against a two-entry FIFO model.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in        = $urandom;
            exp_in_ready = (model_q.size() < 2);
            check("rand.in_ready",  {31'd0, in_ready},  {31'd0, exp_in_ready});
            check("rand.out_valid", {31'd0, out_valid}, {31'd0, (model_q.size() > 0)});
            if (model_q.size() > 0) check("rand.data", pipelined_out, model_q[0]);
            if (out_ready && model_q.size() > 0) void'(model_q.pop_front());
            if (in_valid && exp_in_ready) model_q.push_back(in);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
